// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port Sram arbiter.
// Contents:
//   state_e  - sequencer FSM encoding (IDLE, ACCESS)
//   PORT_IF  - requester id of the instruction-fetch port (m0)
//   PORT_DM  - requester id of the data load/store port (m1)
//   BE_W     - number of byte enables per 32-bit word
package sram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int unsigned BE_W = 4;

endpackage

// File: rtl/sram_arb_pick2.sv
// Combinational 2-way picker, one-hot grant output.
// Build option: SRAM_ARB_RR_EN selects round-robin (hosts a last-winner flop);
// otherwise fixed priority with port 1 (data) beating port 0 (fetch).
// Ports:
//   clk, rst_n  - clock and async active-low reset (last-winner flop only)
//   i_req0/1    - requests from port 0 / port 1
//   i_take      - a grant issued this cycle is actually taken (arbiter idle)
//   o_gnt[1:0]  - one-hot winner, bit n = port n
module sram_arb_pick2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

`ifdef SRAM_ARB_RR_EN
  // Id of the port granted last; resets to PORT_DM so m0 wins the first tie.
  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_DM;
    end else if (i_take && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      o_gnt = (r_last == PORT_DM) ? 2'b01 : 2'b10;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end
  end
`else
  // Fixed priority has no state; the clock/reset/take inputs are unused here.
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_take};

  always_comb begin
    o_gnt = 2'b00;
    if (i_req1) begin
      o_gnt = 2'b10;
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port byte-addressed Sram.
// m0 = instruction fetch, m1 = data load/store. One access in flight at a time:
// grant in IDLE (cycle T), Sram command in ACCESS (T+1), rvalid pulse at T+2.
// Build option: SRAM_ARB_RR_EN = round-robin on ties, else m1 has fixed priority.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   mX_req/we/addr/wdata    - requests (we==0 means read), held until mX_gnt
//   mX_gnt                  - combinational accept, only in IDLE
//   mX_rvalid, mX_rdata     - one-cycle response; rdata is a shared register
//   MemRead, MemWrite       - Sram strobes, active only during ACCESS
//   address, write_data     - latched command, held outside ACCESS
//   read_data               - Sram combinational read data
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic [BE_W-1:0] m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic [BE_W-1:0] m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            MemRead,
  output logic [BE_W-1:0] MemWrite,
  output logic [AW-1:0]   address,
  output logic [DW-1:0]   write_data,
  input  logic [DW-1:0]   read_data
);

  state_e          r_state, w_state_next;
  logic            r_id;
  logic [BE_W-1:0] r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_rvalid;
  logic [1:0]      w_pick;
  logic            w_idle;
  logic            w_grant;

  assign w_idle = (r_state == IDLE);

  sram_arb_pick2 u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .i_take (w_idle),
    .o_gnt  (w_pick)
  );

  assign m0_gnt  = w_idle & w_pick[0];
  assign m1_gnt  = w_idle & w_pick[1];
  assign w_grant = m0_gnt | m1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    MemRead      = 1'b0;
    MemWrite     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_grant) w_state_next = ACCESS;
      end
      ACCESS: begin
        w_state_next = IDLE;
        MemRead      = (r_we == '0);
        MemWrite     = r_we;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= PORT_IF;
      r_we     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= 2'b00;
      if (w_grant) begin
        r_id    <= m1_gnt ? PORT_DM : PORT_IF;
        r_we    <= m1_gnt ? m1_we    : m0_we;
        r_addr  <= m1_gnt ? m1_addr  : m0_addr;
        r_wdata <= m1_gnt ? m1_wdata : m0_wdata;
      end
      if (r_state == ACCESS) begin
        r_rvalid <= (r_id == PORT_DM) ? 2'b10 : 2'b01;
        // Writes leave the read-data register untouched.
        if (r_we == '0) r_rdata <= read_data;
      end
    end
  end

  assign address    = r_addr;
  assign write_data = r_wdata;
  assign m0_rvalid  = r_rvalid[0];
  assign m1_rvalid  = r_rvalid[1];
  assign m0_rdata   = r_rdata;
  assign m1_rdata   = r_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead;
  logic [3:0]  MemWrite;
  logic [31:0] address, write_data, read_data;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed Sram model (4 KiB window), preloaded on the first edge.
  logic [7:0] mem [0:4095];
  bit mem_loaded = 1'b0;
  logic [11:0] ra;
  assign ra = address[11:0];
  assign read_data = MemRead ? {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]}
                             : 32'hxxxx_xxxx;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      {mem[3], mem[2], mem[1], mem[0]}    <= 32'hA0A1A2A3;
      {mem[7], mem[6], mem[5], mem[4]}    <= 32'hB0B1B2B3;
      {mem[11], mem[10], mem[9], mem[8]}  <= 32'hC0C1C2C3;
      mem_loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (MemWrite[i]) mem[ra + 12'(i)] <= write_data[8*i +: 8];
      end
    end
  end

  // Drive a request from a negedge; returns at posedge+1 of the ACCESS cycle.
  task automatic issue(input bit port, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    if (port) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (port ? m1_gnt : m0_gnt) got = 1'b1;
      else begin waited++; @(negedge clk); end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL issue_timeout port %0d: no gnt within 10 cycles", port);
    end
    @(posedge clk); #1;
    if (port) m1_req = 0; else m0_req = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl got %b exp 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
    checks++; if ({MemRead, MemWrite} !== 5'b0) begin errors++;
      $display("FAIL reset_mem got %b exp 00000", {MemRead, MemWrite}); end
    checks++; if ({address, write_data, m0_rdata} !== 96'h0) begin errors++;
      $display("FAIL reset_data got %h exp 0", {address, write_data, m0_rdata}); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    m0_we = 0; m1_we = 0; m0_addr = 32'h10; m1_addr = 32'h20;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef SRAM_ARB_RR_EN
      exp = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
`else
      exp = (k % 2 == 1) ? 2'b00 : 2'b10;
`endif
      checks++; if ({m1_gnt, m0_gnt} !== exp) begin errors++;
        $display("FAIL arb_gnt cycle %0d got %b exp %b", k, {m1_gnt, m0_gnt}, exp); end
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int w;
    issue(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL wr_wait got %0d exp 0", w); end
    @(negedge clk);
    checks++; if ({MemRead, MemWrite} !== 5'b0_1111) begin errors++;
      $display("FAIL wr_strobe got %b exp 01111", {MemRead, MemWrite}); end
    checks++; if ({address, write_data} !== {32'h100, 32'hDEADBEEF}) begin errors++;
      $display("FAIL wr_cmd got %h exp %h", {address, write_data}, {32'h100, 32'hDEADBEEF}); end
    @(negedge clk);
    checks++; if ({m1_rvalid, m0_rvalid, MemWrite} !== 6'b10_0000) begin errors++;
      $display("FAIL wr_ack got %b exp 100000", {m1_rvalid, m0_rvalid, MemWrite}); end
    issue(1'b0, 4'h0, 32'h100, 32'h0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL rd_wait got %0d exp 0", w); end
    @(negedge clk);
    checks++; if ({MemRead, MemWrite} !== 5'b1_0000) begin errors++;
      $display("FAIL rd_strobe got %b exp 10000", {MemRead, MemWrite}); end
    @(negedge clk);
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin errors++;
      $display("FAIL rd_rvalid got %b exp 10", {m0_rvalid, m1_rvalid}); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data got %h exp deadbeef", m0_rdata); end
  endtask

  task automatic test_partial_write();
    int w;
    issue(1'b1, 4'hF, 32'h200, 32'h11223344, w);
    @(negedge clk); @(negedge clk);
    issue(1'b1, 4'b0010, 32'h200, 32'h0000AA00, w);
    @(negedge clk);
    checks++; if (MemWrite !== 4'b0010) begin errors++;
      $display("FAIL pw_strobe got %b exp 0010", MemWrite); end
    @(negedge clk);
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL pw_rdata_hold got %h exp deadbeef", m0_rdata); end
    issue(1'b0, 4'h0, 32'h200, 32'h0, w);
    @(negedge clk); @(negedge clk);
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1122AA44}) begin errors++;
      $display("FAIL pw_read got %b/%h exp 1/1122aa44", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs = '{32'h0, 32'h4, 32'h8};
    words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
    m0_we = 0; m0_addr = addrs[0]; m0_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m0_gnt !== 1'b1) begin errors++;
        $display("FAIL b2b_gnt %0d got %b exp 1", i, m0_gnt); end
      if (i > 0) begin
        checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, words[i-1]}) begin errors++;
          $display("FAIL b2b_data %0d got %b/%h exp 1/%h", i - 1, m0_rvalid, m0_rdata,
                   words[i-1]); end
      end
      @(posedge clk); #1;
      if (i < 2) m0_addr = addrs[i+1]; else m0_req = 0;
      @(negedge clk);
      checks++; if ({m0_gnt, MemRead, address} !== {2'b01, addrs[i]}) begin errors++;
        $display("FAIL b2b_access %0d got %b/%b/%h exp 0/1/%h", i, m0_gnt, MemRead, address,
                 addrs[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if ({m0_gnt, m0_rvalid, m0_rdata} !== {2'b01, words[2]}) begin errors++;
      $display("FAIL b2b_last got %b/%b/%h exp 0/1/%h", m0_gnt, m0_rvalid, m0_rdata, words[2]);
    end
  endtask

  task automatic test_withdraw();
    int w;
    @(negedge clk);
    issue(1'b1, 4'hF, 32'h300, 32'h12345678, w);
    m0_req = 1; m0_we = 4'hF; m0_addr = 32'h400; m0_wdata = 32'h55555555;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++;
      $display("FAIL wd_gnt_access got %b exp 0", m0_gnt); end
    m0_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({m0_gnt, m0_rvalid, MemRead, MemWrite} !== 7'b0) begin errors++;
        $display("FAIL wd_idle %0d got %b exp 0", k, {m0_gnt, m0_rvalid, MemRead, MemWrite});
      end
    end
    checks++; if ({mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]} !== 32'h0) begin
      errors++; $display("FAIL wd_nowrite got %h exp 0",
                         {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]}); end
    checks++; if ({mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]} !== 32'h12345678)
    begin errors++; $display("FAIL wd_m1write got %h exp 12345678",
                             {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}); end
  endtask

  task automatic test_reset_mid_access();
    int w;
    issue(1'b0, 4'h0, 32'h100, 32'h0, w);
    @(negedge clk);
    checks++; if (MemRead !== 1'b1) begin errors++;
      $display("FAIL rst_pre_read got %b exp 1", MemRead); end
    #1 rst_n = 0;
    #1;
    checks++; if ({MemRead, MemWrite, m0_gnt, m1_gnt} !== 7'b0) begin errors++;
      $display("FAIL rst_async_ctrl got %b exp 0", {MemRead, MemWrite, m0_gnt, m1_gnt}); end
    checks++; if ({address, write_data, m0_rdata, m1_rdata} !== 128'h0) begin errors++;
      $display("FAIL rst_async_data got %h exp 0", {address, write_data, m0_rdata}); end
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({m0_rvalid, m1_rvalid, MemRead} !== 3'b0) begin errors++;
        $display("FAIL rst_no_rvalid %0d got %b exp 000", k, {m0_rvalid, m1_rvalid, MemRead});
      end
      @(negedge clk);
    end
    m0_we = 0; m1_we = 0; m0_req = 1; m1_req = 1;
    #1;
`ifdef SRAM_ARB_RR_EN
    checks++; if ({m1_gnt, m0_gnt} !== 2'b01) begin errors++;
      $display("FAIL rst_tie got %b exp 01", {m1_gnt, m0_gnt}); end
`else
    checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin errors++;
      $display("FAIL rst_tie got %b exp 10", {m1_gnt, m0_gnt}); end
`endif
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_arbitration();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_withdraw();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
